// File: rtl/blackjack_btn_cmd_queue_pkg.sv
// Shared blackjack command encoding: button index equals command code.
package blackjack_pkg;

    localparam int unsigned NUM_CMD = 4;
    localparam int unsigned CMD_T_W = $clog2(NUM_CMD);

    typedef logic [CMD_T_W-1:0] cmd_t;

    localparam cmd_t CMD_HIT     = CMD_T_W'(0);
    localparam cmd_t CMD_STAND   = CMD_T_W'(1);
    localparam cmd_t CMD_DEAL    = CMD_T_W'(2);
    localparam cmd_t CMD_NEWGAME = CMD_T_W'(3);

endpackage

// File: rtl/blackjack_btn_cmd_queue_if.sv
// Button-pulse in / command-stream out bundle between debouncers, queue and game FSM.
interface blackjack_btn_cmd_queue_if
    import blackjack_pkg::*;
#(
    parameter int unsigned NUM_BTN = NUM_CMD,
    parameter int unsigned DEPTH   = 4
) ();
    localparam int unsigned CMD_W = $clog2(NUM_BTN);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [NUM_BTN-1:0] btn_pulse;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [CMD_W-1:0]   cmd_code;
    logic [LVL_W-1:0]   level;
    logic               overflow;
    logic               ovf_clr;

    modport master (
        output btn_pulse, cmd_ready, ovf_clr,
        input  cmd_valid, cmd_code, level, overflow
    );

    modport slave (
        input  btn_pulse, cmd_ready, ovf_clr,
        output cmd_valid, cmd_code, level, overflow
    );

endinterface

// File: rtl/blackjack_btn_cmd_queue_cmd_fifo.sv
// Circular-buffer command FIFO; pointer MSB separates full from empty.
module cmd_fifo #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [W-1:0]         din,
    output logic [W-1:0]         dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                 full,
    output logic                 empty
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [W-1:0]     mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == PTR_W'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/blackjack_btn_cmd_queue.sv
// Serializes debounced button presses by fixed priority into an ordered command FIFO.
module blackjack_btn_cmd_queue
    import blackjack_pkg::*;
#(
    parameter int unsigned NUM_BTN = NUM_CMD,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    blackjack_btn_cmd_queue_if.slave        bus
);
    localparam int unsigned CMD_W = $clog2(NUM_BTN);

    logic [NUM_BTN-1:0] pend;
    logic [NUM_BTN-1:0] cand;
    logic [NUM_BTN-1:0] push_oh;
    logic [NUM_BTN-1:0] pend_nxt;
    logic [CMD_W-1:0]   push_code;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               ovf_set;
    logic               overflow_q;

    // Lowest-index candidate wins; scanning downward leaves the lowest set bit last.
    always_comb begin
        cand      = pend | bus.btn_pulse;
        push_oh   = '0;
        push_code = '0;
        for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                push_oh    = '0;
                push_oh[i] = 1'b1;
                push_code  = CMD_W'(i);
            end
        end
        pop      = ~empty & bus.cmd_ready;
        push     = (|cand) & (~full | pop);
        pend_nxt = cand & ~({NUM_BTN{push}} & push_oh);
        ovf_set  = |(bus.btn_pulse & pend & ~({NUM_BTN{push}} & push_oh));
    end

    // A fresh merge takes precedence over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            overflow_q <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (ovf_set)          overflow_q <= 1'b1;
            else if (bus.ovf_clr) overflow_q <= 1'b0;
        end
    end

    cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_code),
        .dout  (bus.cmd_code),
        .level (bus.level),
        .full  (full),
        .empty (empty)
    );

    assign bus.cmd_valid = ~empty;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_blackjack_btn_cmd_queue.sv
// Directed bench for blackjack_btn_cmd_queue with a queue-based reference model.
module tb_blackjack_btn_cmd_queue;
    import blackjack_pkg::*;

    localparam int NB = 4;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int       m_q[$];
    logic [3:0] m_pend = '0;
    bit       m_ovf = 1'b0;

    blackjack_btn_cmd_queue_if #(.NUM_BTN(NB), .DEPTH(DP)) bus ();

    blackjack_btn_cmd_queue #(.NUM_BTN(NB), .DEPTH(DP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input int c);
        logic [3:0] one = 4'd1;
        return one << c;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model: pending set, FIFO as a queue, sticky overflow, evaluated at each clock edge.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_pend = '0;
            m_ovf  = 1'b0;
        end else begin
            logic [3:0] c;
            logic [3:0] merged;
            bit do_pop, do_push;
            int pidx;
            c       = m_pend | bus.btn_pulse;
            do_pop  = (m_q.size() != 0) && bus.cmd_ready;
            do_push = (c != 0) && ((m_q.size() < DP) || do_pop);
            pidx    = -1;
            if (do_push) begin
                for (int i = 0; i < NB; i++) begin
                    if (c[i] && pidx < 0) pidx = i;
                end
            end
            merged = bus.btn_pulse & m_pend;
            if (do_push) merged[pidx] = 1'b0;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(pidx);
                c[pidx] = 1'b0;
            end
            m_pend = c;
            if (merged != 0)      m_ovf = 1'b1;
            else if (bus.ovf_clr) m_ovf = 1'b0;
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            check("cmp_valid", int'(bus.cmd_valid), int'(m_q.size() != 0));
            check("cmp_code", int'(bus.cmd_code), (m_q.size() != 0) ? m_q[0] : 0);
            check("cmp_level", int'(bus.level), m_q.size());
            check("cmp_overflow", int'(bus.overflow), int'(m_ovf));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int exp_seq[6];
        rst_n         = 1'b0;
        bus.btn_pulse = '0;
        bus.cmd_ready = 1'b0;
        bus.ovf_clr   = 1'b0;

        // reset with random presses
        repeat (4) begin
            step();
            bus.btn_pulse = 4'($urandom);
        end
        check("rst_hold_valid", int'(bus.cmd_valid), 0);
        check("rst_hold_level", int'(bus.level), 0);
        bus.btn_pulse = '0;
        rst_n = 1'b1;
        step();
        check("rst_valid", int'(bus.cmd_valid), 0);
        check("rst_code", int'(bus.cmd_code), 0);
        check("rst_level", int'(bus.level), 0);
        check("rst_overflow", int'(bus.overflow), 0);

        // single press consumed immediately
        bus.cmd_ready = 1'b1;
        bus.btn_pulse = oh(int'(CMD_STAND));
        step();
        bus.btn_pulse = '0;
        check("single_valid", int'(bus.cmd_valid), 1);
        check("single_code", int'(bus.cmd_code), 1);
        check("single_level", int'(bus.level), 1);
        step();
        check("single_valid_after", int'(bus.cmd_valid), 0);
        check("single_level_after", int'(bus.level), 0);

        // simultaneous presses serialize lowest first
        bus.cmd_ready = 1'b0;
        bus.btn_pulse = 4'b1010;
        step();
        bus.btn_pulse = '0;
        check("simul_level_t", int'(bus.level), 1);
        check("simul_code_t", int'(bus.cmd_code), 1);
        step();
        check("simul_level_t1", int'(bus.level), 2);
        bus.cmd_ready = 1'b1;
        check("simul_first", int'(bus.cmd_code), 1);
        step();
        check("simul_second", int'(bus.cmd_code), 3);
        check("simul_second_lvl", int'(bus.level), 1);
        step();
        check("simul_empty", int'(bus.cmd_valid), 0);

        // fill and backpressure
        bus.cmd_ready = 1'b0;
        foreach (exp_seq[k]) exp_seq[k] = (k < 4) ? k : k - 4;
        for (int k = 0; k < 6; k++) begin
            bus.btn_pulse = oh(exp_seq[k]);
            step();
        end
        bus.btn_pulse = '0;
        check("fill_level", int'(bus.level), 4);
        check("fill_model_pend", int'(m_pend), 3);
        check("fill_overflow", int'(bus.overflow), 0);
        bus.cmd_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("fill_drain_valid", int'(bus.cmd_valid), 1);
            check("fill_drain_code", int'(bus.cmd_code), exp_seq[k]);
            step();
        end
        check("fill_drained", int'(bus.cmd_valid), 0);

        // overflow on repeat press of a pending button
        bus.cmd_ready = 1'b0;
        foreach (exp_seq[k]) exp_seq[k] = 0;
        exp_seq[0] = int'(CMD_HIT);
        exp_seq[1] = int'(CMD_STAND);
        exp_seq[2] = int'(CMD_NEWGAME);
        exp_seq[3] = int'(CMD_HIT);
        exp_seq[4] = int'(CMD_DEAL);
        for (int k = 0; k < 5; k++) begin
            bus.btn_pulse = oh(exp_seq[k]);
            step();
        end
        check("ovf_full_level", int'(bus.level), 4);
        check("ovf_model_pend", int'(m_pend), 4);
        check("ovf_before", int'(bus.overflow), 0);
        bus.btn_pulse = oh(int'(CMD_DEAL));
        step();
        bus.btn_pulse = '0;
        check("ovf_set", int'(bus.overflow), 1);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", int'(bus.overflow), 0);
        bus.ovf_clr   = 1'b1;
        bus.btn_pulse = oh(int'(CMD_DEAL));
        step();
        bus.ovf_clr   = 1'b0;
        bus.btn_pulse = '0;
        check("ovf_set_wins", int'(bus.overflow), 1);
        bus.cmd_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.cmd_valid && bus.cmd_code == 2'(CMD_DEAL)) cnt++;
            step();
        end
        check("ovf_one_deal", cnt, 1);
        check("ovf_drained", int'(bus.level), 0);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check("ovf_final_clear", int'(bus.overflow), 0);

        // asynchronous reset mid-operation
        bus.cmd_ready = 1'b0;
        bus.btn_pulse = 4'b1111;
        step();
        bus.btn_pulse = '0;
        step();
        step();
        check("midrst_level_before", int'(bus.level), 3);
        check("midrst_model_pend", int'(m_pend), 8);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", int'(bus.cmd_valid), 0);
        check("midrst_level", int'(bus.level), 0);
        check("midrst_code", int'(bus.cmd_code), 0);
        repeat (3) begin
            bus.btn_pulse = 4'($urandom);
            step();
        end
        bus.btn_pulse = '0;
        rst_n = 1'b1;
        bus.cmd_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.cmd_valid) cnt++;
        end
        check("midrst_nothing_after", cnt, 0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blackjack_btn_cmd_queue.md
# blackjack_btn_cmd_queue

Collects single-cycle press pulses from the per-button debouncers and turns them into an ordered stream of game commands for the blackjack control FSM. Presses that arrive together or while the FSM is busy are never lost while buffer space exists: they are held as pending requests, serialized by fixed priority, and queued in a small FIFO. The block sits between the debouncer bank and the game controller.

## Interface
- NUM_BTN, 4: number of button inputs; button index = command code
- DEPTH, 4: FIFO depth in entries; power of two, ≥2
- CMD_W, $clog2(NUM_BTN): command code width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- btn_pulse  in  NUM_BTN  one-cycle press pulses from debouncers, any combination per cycle
- cmd_valid  out  1  head command available
- cmd_ready  in  1  consumer accepts head when cmd_valid & cmd_ready
- cmd_code  out  CMD_W  head command; forced to 0 when cmd_valid=0
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- overflow  out  1  sticky: a press was merged into an already-pending press of the same button
- ovf_clr  in  1  synchronous clear of overflow

## Operation
- Pending register `pend[NUM_BTN]`. Each cycle, candidate set C = pend | btn_pulse.
- Push condition: C≠0 and (level<DEPTH or pop this cycle). Pushed entry = lowest set index of C.
- pend_next = C with the pushed bit cleared; if no push, pend_next = C.
- Pop: cmd_valid & cmd_ready; advances the read pointer. Pop and push in the same cycle are legal at any level, including full, where level stays DEPTH.
- Overflow: set when btn_pulse[i]=1 and pend[i]=1 and bit i is not the pushed bit this cycle. ovf_clr clears it; a simultaneous set wins over clear.
- FIFO is a circular buffer with read/write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty, and both pointers wrap modulo 2·DEPTH.
- cmd_valid = (level≠0); cmd_code = mem[rd_ptr] when valid, else 0.
- No reordering: commands leave in push order. Within a cycle, priority goes to the lower index.

## Timing
- Reset (asynchronous assert, release on clk edge): pend=0, pointers=0, level=0, cmd_valid=0, cmd_code=0, overflow=0. Pulses during reset are discarded.
- Latency: a pulse at edge t into an empty FIFO gives cmd_valid=1 and the code after edge t, valid from cycle t+1. There is no combinational path from btn_pulse to the outputs.
- At most one push and one pop per cycle. With k simultaneous pulses and an empty FIFO, entries appear on k consecutive cycles.
- When full with no pop, pend holds. Only a repeat press of an already-pending button is merged and flagged.
- level updates on the edge of the push/pop: +1 for push only, −1 for pop only, unchanged for both or neither.
- Reset mid-operation drops all queued and pending commands immediately.

## Structure
- Shared package `blackjack_pkg`: command localparams CMD_HIT=0, CMD_STAND=1, CMD_DEAL=2, CMD_NEWGAME=3, and the cmd_t width. The debouncer bank indexes btn_pulse by these constants.
- Sub-module `cmd_fifo`: a synchronous FIFO with push, pop, data in/out, level, full and empty. The top level holds the pending register, the priority encoder and the overflow logic.

## Test plan
- Reset: hold rst_n=0 with random btn_pulse -> after release, cmd_valid=0, cmd_code=0, level=0, overflow=0.
- Single press: btn_pulse=4'b0010 at edge 5 with cmd_ready=1 -> cmd_valid=1, cmd_code=1 during cycle 6 only; level returns to 0.
- Simultaneous presses: btn_pulse=4'b1010 at edge t with cmd_ready=0 -> level=1 after t and 2 after t+1. Raising ready then yields codes 1 then 3 on consecutive cycles.
- Fill and backpressure: cmd_ready=0; pulse buttons 0,1,2,3 on separate cycles, then 0 and 1 again -> level=4, pend=4'b0011, overflow=0. Ready=1 for 6 cycles -> codes 0,1,2,3,0,1 in order.
- Overflow: full FIFO with pend[2]=1; pulse button 2 -> overflow=1 and only one code-2 entry is later delivered. ovf_clr pulse -> overflow=0. ovf_clr coincident with a new merge -> overflow stays 1.
- Reset mid-operation: level=3 with pend≠0; drop rst_n asynchronously between edges -> cmd_valid=0 and level=0 without a clock edge, and nothing is delivered after release.
